data_mem_responder: RTL and testbench

//  Memory-side responder for the load/store queue and instruction fetch unit.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_rsp_fifo.sv | 48 ++++
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, FSM states and response record for the data memory responder.
package mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  typedef enum logic {MEM_INIT, MEM_RUN} mem_state_e;

  typedef struct packed {
    logic              store;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } mem_rsp_t;
endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO with empty-bypass: a push into an empty FIFO is visible the same cycle, 0 latency.
// Consumer stalls via out_rdy; producer must honour credits derived from count (no full flag).
module mem_rsp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  mem_rsp_t                   push_dat,
  output logic                       out_vld,
  output mem_rsp_t                   out_dat,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  mem_rsp_t         slots_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty, wr_en, rd_en;

  assign empty   = (cnt_q == '0);
  assign out_vld = !empty || push_vld;
  assign out_dat = empty ? push_dat : slots_q[rd_ptr_q];
  assign rd_en   = out_rdy && !empty;
  // A push consumed in the same cycle it arrives at an empty FIFO is never stored.
  assign wr_en   = push_vld && !(empty && out_rdy);
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) slots_q[wr_ptr_q] <= push_dat;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Single-port word array serving LSQ loads/stores (priority) and instruction fetch; responses 1 cycle after accept.
// req_ready is a registered credit check on FIFO+inflight; fetch waits while a data request fires. MEM_RSP_PARITY_EN adds parity outputs.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_store,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  output logic              init_done
`ifdef MEM_RSP_PARITY_EN
  ,
  output logic              rsp_parity,
  output logic              if_parity
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH+1);

  mem_state_e        state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              mem_we, mem_re;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdat;
  logic              run, req_fire;
  logic              pipe_vld_q, if_vld_q;
  mem_rsp_t          pipe_q, push_dat, out_dat;
  logic [CNT_W-1:0]  fifo_count;

  assign run       = (state_q == MEM_RUN);
  assign init_done = run;
  // The response still in the read pipe holds a credit until it lands in the FIFO.
  assign req_ready = run && ((fifo_count + CNT_W'(pipe_vld_q)) < CNT_W'(RSP_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign if_gnt    = run && if_req && !req_fire;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_idx    = req_addr[IDX_W-1:0];
    mem_wdat   = req_wdata;
    case (state_q)
      MEM_INIT: begin
        mem_we     = 1'b1;
        mem_idx    = init_cnt_q;
        mem_wdat   = '0;
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == IDX_W'(DEPTH-1)) state_d = MEM_RUN;
      end
      MEM_RUN: begin
        if (req_fire) begin
          mem_we = req_we;
          mem_re = !req_we;
        end else if (if_gnt) begin
          mem_re  = 1'b1;
          mem_idx = if_addr[IDX_W-1:0];
        end
      end
      default: state_d = MEM_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MEM_INIT;
      init_cnt_q <= '0;
      pipe_vld_q <= 1'b0;
      if_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pipe_vld_q <= req_fire;
      if_vld_q   <= if_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdat;
    else if (mem_re) rd_q <= mem[mem_idx];
    if (req_fire) pipe_q <= '{store: req_we, tag: req_tag, data: req_wdata};
  end

  always_comb begin
    push_dat = pipe_q;
    if (!pipe_q.store) push_dat.data = rd_q;
  end

  mem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (pipe_vld_q),
    .push_dat (push_dat),
    .out_vld  (rsp_valid),
    .out_dat  (out_dat),
    .out_rdy  (rsp_ready),
    .count    (fifo_count)
  );

  assign rsp_store = out_dat.store;
  assign rsp_tag   = out_dat.tag;
  assign rsp_data  = out_dat.data;
  assign if_valid  = if_vld_q;
  assign if_data   = rd_q;

`ifdef MEM_RSP_PARITY_EN
  assign rsp_parity = rsp_valid && (^{rsp_store, rsp_tag, rsp_data});
  assign if_parity  = if_valid && (^if_data);
`endif

  if (IDX_W < ADDR_W) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W], if_addr[ADDR_W-1:IDX_W]};
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a queue/array reference model.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH     = 16;
  localparam int RSP_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0, req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              rsp_ready = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              req_ready, rsp_valid, rsp_store, if_gnt, if_valid, init_done;
  logic [DATA_W-1:0] rsp_data, if_data;
  logic [TAG_W-1:0]  rsp_tag;
`ifdef MEM_RSP_PARITY_EN
  logic              rsp_parity, if_parity;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_store(rsp_store),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_data(if_data), .init_done(init_done)
`ifdef MEM_RSP_PARITY_EN
    , .rsp_parity(rsp_parity), .if_parity(if_parity)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array plus queue of responses owed, updated once per clock edge.
  logic [DATA_W-1:0] mmem [DEPTH];
  mem_rsp_t          exp_q[$];
  mem_rsp_t          seen_q[$];
  mem_rsp_t          m_front;
  int                init_left = DEPTH;
  logic              p_reset = 1'b1, p_acc = 1'b0, p_we = 1'b0, p_gnt = 1'b0;
  logic [3:0]        p_idx = '0, p_fidx = '0;
  logic [DATA_W-1:0] p_wdata = '0;
  logic [TAG_W-1:0]  p_tag = '0;
  logic              fv_exp = 1'b0;
  logic [DATA_W-1:0] fd_exp = '0;
  logic              m_run, m_rdy;

  always @(negedge clk) begin
    // Apply what the previous edge did.
    if (p_reset) begin
      init_left = DEPTH;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      fv_exp = 1'b0;
    end else begin
      if (init_left > 0) init_left--;
      if (p_acc) begin
        if (p_we) begin
          mmem[p_idx] = p_wdata;
          exp_q.push_back(mem_rsp_t'{store: 1'b1, tag: p_tag, data: p_wdata});
        end else begin
          exp_q.push_back(mem_rsp_t'{store: 1'b0, tag: p_tag, data: mmem[p_idx]});
        end
      end
      fv_exp = p_gnt;
      if (p_gnt) fd_exp = mmem[p_fidx];
    end
    if (!reset) begin
      m_run = (init_left == 0);
      m_rdy = m_run && (exp_q.size() < RSP_DEPTH);
      check("init_done", 32'(init_done), 32'(m_run));
      check("req_ready", 32'(req_ready), 32'(m_rdy));
      check("if_gnt", 32'(if_gnt), 32'(m_run && if_req && !(req_valid && m_rdy)));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
      if (rsp_valid && exp_q.size() > 0) begin
        m_front = exp_q[0];
        check("rsp_store", 32'(rsp_store), 32'(m_front.store));
        check("rsp_tag", 32'(rsp_tag), 32'(m_front.tag));
        check("rsp_data", 32'(rsp_data), 32'(m_front.data));
`ifdef MEM_RSP_PARITY_EN
        check("rsp_parity", 32'(rsp_parity), 32'(^m_front));
`endif
      end
      check("if_valid", 32'(if_valid), 32'(fv_exp));
      if (fv_exp) begin
        check("if_data", 32'(if_data), 32'(fd_exp));
`ifdef MEM_RSP_PARITY_EN
        check("if_parity", 32'(if_parity), 32'(^fd_exp));
`endif
      end
      if (rsp_valid && rsp_ready) begin
        seen_q.push_back(mem_rsp_t'{store: rsp_store, tag: rsp_tag, data: rsp_data});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    p_reset = reset;
    p_acc   = req_valid && req_ready;
    p_we    = req_we;
    p_idx   = req_addr[3:0];
    p_wdata = req_wdata;
    p_tag   = req_tag;
    p_gnt   = if_gnt;
    p_fidx  = if_addr[3:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic [TAG_W-1:0] tag);
    logic acc;
    int   k;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_tag = tag;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 100) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      k++;
    end
    req_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_seen(input int n, input string name);
    int k;
    k = 0;
    while (seen_q.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(seen_q.size() >= n), 32'd1);
    tick();
  endtask

  int   acc_cnt;
  logic g;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Init sequence: a load held across INIT, plus a held fetch.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h005; req_tag = 3'd0;
    if_req = 1'b1; if_addr = 12'h00C; reset = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < DEPTH) begin
        check("t1_ready_low", 32'(req_ready), 32'd0);
        check("t1_gnt_low", 32'(if_gnt), 32'd0);
      end
      if (i == DEPTH - 1) check("t1_init_low", 32'(init_done), 32'd0);
      if (i == DEPTH) check("t1_init_high", 32'(init_done), 32'd1);
    end
    tick();
    req_valid = 1'b0;
    tick();
    if_req = 1'b0;
    wait_seen(1, "t1_rsp_timeout");
    check("t1_load_rsp", 32'(seen_q[0]), 32'({1'b0, 3'd0, 16'h0000}));
    seen_q.delete();

    // Store then load the same word back to back.
    send(1'b1, 12'h00A, 16'h1234, 3'd2);
    send(1'b0, 12'h00A, 16'h0000, 3'd3);
    wait_seen(2, "t2_rsp_timeout");
    check("t2_first", 32'(seen_q[0]), 32'({1'b1, 3'd2, 16'h1234}));
    check("t2_second", 32'(seen_q[1]), 32'({1'b0, 3'd3, 16'h1234}));
    seen_q.delete();

    // Credit exhaustion with the response side stalled.
    rsp_ready = 1'b0;
    acc_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 12'(i);
      req_tag = 3'(acc_cnt);
      @(negedge clk);
      if (req_ready) acc_cnt++;
      tick();
    end
    req_valid = 1'b0;
    check("t3_accepted", 32'(acc_cnt), 32'd4);
    @(negedge clk);
    check("t3_ready_low", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b1;
    wait_seen(4, "t3_rsp_timeout");
    for (int i = 0; i < 4; i++) check("t3_tag_order", 32'(seen_q[i].tag), 32'(i));
    @(negedge clk);
    check("t3_ready_back", 32'(req_ready), 32'd1);
    tick();
    seen_q.delete();

    // Fetch held off by a 3-cycle data stream.
    send(1'b1, 12'h010, 16'hBEEF, 3'd1);
    if_req = 1'b1; if_addr = 12'h010;
    req_valid = 1'b1; req_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_addr = 12'(32 + k);
      req_tag = 3'(4 + k);
      @(negedge clk);
      check("t4_gnt_low", 32'(if_gnt), 32'd0);
      check("t4_req_ready", 32'(req_ready), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("t4_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("t4_if_valid", 32'(if_valid), 32'd1);
    check("t4_if_data", 32'(if_data), 32'h0000BEEF);
    tick();
    wait_seen(4, "t4_rsp_timeout");
    seen_q.delete();

    // Reset with two queued responses.
    rsp_ready = 1'b0;
    send(1'b0, 12'h001, 16'h0000, 3'd5);
    send(1'b0, 12'h002, 16'h0000, 3'd6);
    tick();
    @(negedge clk);
    check("t5_queued", 32'(rsp_valid), 32'd1);
    tick();
    reset = 1'b1;
    seen_q.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_rsp_cleared", 32'(rsp_valid), 32'd0);
    check("t5_init_low", 32'(init_done), 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && !init_done; k++) @(negedge clk);
    check("t5_init_again", 32'(init_done), 32'd1);
    repeat (5) tick();
    check("t5_no_stale", 32'(seen_q.size()), 32'd0);

`ifdef MEM_RSP_PARITY_EN
    send(1'b1, 12'h020, 16'h0007, 3'd0);
    repeat (2) tick();
    rsp_ready = 1'b0;
    send(1'b0, 12'h020, 16'h0000, 3'd1);
    @(negedge clk);
    check("t6_rsp_data", 32'(rsp_data), 32'h7);
    check("t6_rsp_parity", 32'(rsp_parity), 32'd0);
    tick();
    rsp_ready = 1'b1;
    send(1'b1, 12'h003, 16'h0001, 3'd2);
    if_req = 1'b1; if_addr = 12'h003;
    @(negedge clk);
    check("t6_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("t6_if_parity", 32'(if_parity), 32'd1);
    tick();
`endif

    // Randomized traffic with one mid-run reset.
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      g = if_gnt;
      tick();
      if (it == 1500) begin
        reset = 1'b1;
        req_valid = 1'b0;
        if_req = 1'b0;
      end else begin
        reset     = 1'b0;
        rsp_ready = ($urandom_range(0, 3) != 0);
        req_valid = ($urandom_range(0, 2) != 0);
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 12'($urandom);
        req_wdata = 16'($urandom);
        req_tag   = 3'($urandom);
        if (!if_req || g) begin
          if_req  = ($urandom_range(0, 2) == 0);
          if_addr = 12'($urandom);
        end
      end
      if (seen_q.size() > 64) seen_q.delete();
    end
    req_valid = 1'b0;
    if_req = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
